// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace buffer: record kinds, FSM states, record width.
// Build option TRACE_CYCLE_STAMP_EN widens each record with a cycle stamp.
package trace_pkg;

    localparam int unsigned KIND_W = 3;

    localparam logic [KIND_W-1:0] KIND_NOP  = 3'd0;
    localparam logic [KIND_W-1:0] KIND_REG  = 3'd1;
    localparam logic [KIND_W-1:0] KIND_LD   = 3'd2;
    localparam logic [KIND_W-1:0] KIND_ST   = 3'd3;
    localparam logic [KIND_W-1:0] KIND_HALT = 3'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } traceState_t;

`ifdef TRACE_CYCLE_STAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    // Packed record: inum, pc, inst, kind, reg, value, addr [, cycle stamp]
    function automatic int unsigned recordWidth(input int unsigned dataW,
                                                input int unsigned regAw,
                                                input int unsigned cntW);
        return cntW + 4 * dataW + KIND_W + regAw + (STAMP_EN ? cntW : 32'd0);
    endfunction

    // Halt wins, then load, register write, store; anything else is a NOP/branch
    function automatic logic [KIND_W-1:0] classify(input logic halt,
                                                   input logic regWrite,
                                                   input logic memRead,
                                                   input logic memWrite);
        if (halt)                     return KIND_HALT;
        else if (regWrite && memRead) return KIND_LD;
        else if (regWrite)            return KIND_REG;
        else if (memWrite)            return KIND_ST;
        else                          return KIND_NOP;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic WIDTH x DEPTH synchronous FIFO; head entry is presented on dout.
// Push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;
    logic [CW-1:0]    countNext;

    assign dout = mem[rdPtr];

    always_comb begin
        doPush    = push && (!full || pop);
        doPop     = pop && !empty;
        countNext = count;
        if (doPush && !doPop)
            countNext = count + CW'(1);
        else if (!doPush && doPop)
            countNext = count - CW'(1);
    end

    // Storage is cleared on reset so the head reads zero until first write
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= din;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (doPop)
                rdPtr <= rdPtr + AW'(1);
            count <= countNext;
            full  <= (countNext == CW'(DEPTH));
            empty <= (countNext == '0);
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: classifies retired instructions into records, queues and drains them.
// Define TRACE_CYCLE_STAMP_EN to add the out_cycle port and per-entry cycle stamps.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ret_valid,
    input  logic [DATA_W-1:0] ret_pc,
    input  logic [DATA_W-1:0] ret_inst,
    input  logic              ret_reg_write,
    input  logic [REG_AW-1:0] ret_write_reg,
    input  logic [DATA_W-1:0] ret_write_data,
    input  logic              ret_mem_read,
    input  logic              ret_mem_write,
    input  logic [DATA_W-1:0] ret_mem_addr,
    input  logic [DATA_W-1:0] ret_mem_data,
    input  logic              ret_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_inum,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic [2:0]        out_kind,
    output logic [REG_AW-1:0] out_reg,
    output logic [DATA_W-1:0] out_value,
    output logic [DATA_W-1:0] out_addr,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [CNT_W-1:0]  out_cycle,
`endif
    output logic              stall_req,
    output logic              overflow,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned REC_W = recordWidth(DATA_W, REG_AW, CNT_W);

    traceState_t       state;
    logic [2:0]        retKind;
    logic [REG_AW-1:0] retReg;
    logic [DATA_W-1:0] retValue;
    logic [DATA_W-1:0] retAddr;
    logic [REC_W-1:0]  pushRec;
    logic [REC_W-1:0]  headRec;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CW-1:0]     fifoCount;
    logic              accept;
    logic              pop;
    logic              pushEn;
    logic              drop;
    logic              drainEmpty;

    always_comb begin
        retKind  = classify(ret_halt, ret_reg_write, ret_mem_read, ret_mem_write);
        retReg   = '0;
        retValue = '0;
        retAddr  = '0;
        case (retKind)
            KIND_REG: begin
                retReg   = ret_write_reg;
                retValue = ret_write_data;
            end
            KIND_LD: begin
                retReg   = ret_write_reg;
                retValue = ret_write_data;
                retAddr  = ret_mem_addr;
            end
            KIND_ST: begin
                retValue = ret_mem_data;
                retAddr  = ret_mem_addr;
            end
            default: ;
        endcase
    end

    assign out_valid  = !fifoEmpty;
    assign stall_req  = fifoFull;
    assign pop        = out_valid && out_ready;
    assign accept     = ret_valid && (state == RUN);
    assign pushEn     = accept && (!fifoFull || pop);
    assign drop       = accept && fifoFull && !pop;
    // DRAIN never pushes, so the queue empties when the last entry pops
    assign drainEmpty = fifoEmpty || ((fifoCount == CW'(1)) && pop);

`ifdef TRACE_CYCLE_STAMP_EN
    assign pushRec = {inst_count, ret_pc, ret_inst, retKind, retReg, retValue, retAddr, cycle_count};
    assign {out_inum, out_pc, out_inst, out_kind, out_reg, out_value, out_addr, out_cycle} = headRec;
`else
    assign pushRec = {inst_count, ret_pc, ret_inst, retKind, retReg, retValue, retAddr};
    assign {out_inum, out_pc, out_inst, out_kind, out_reg, out_value, out_addr} = headRec;
`endif

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pushEn),
        .pop   (pop),
        .din   (pushRec),
        .dout  (headRec),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // Counters, sticky overflow and the RUN/DRAIN/DONE sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            inst_count  <= '0;
            cycle_count <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (state != DONE && cycle_count != '1)
                cycle_count <= cycle_count + CNT_W'(1);
            if (accept && inst_count != '1)
                inst_count <= inst_count + CNT_W'(1);
            if (drop)
                overflow <= 1'b1;
            case (state)
                RUN: begin
                    if (accept && ret_halt)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (drainEmpty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    done  <= 1'b1;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: queue-based reference model plus decoupled monitor.
module tb_retire_trace_buffer;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              ret_valid;
    logic [DATA_W-1:0] ret_pc;
    logic [DATA_W-1:0] ret_inst;
    logic              ret_reg_write;
    logic [REG_AW-1:0] ret_write_reg;
    logic [DATA_W-1:0] ret_write_data;
    logic              ret_mem_read;
    logic              ret_mem_write;
    logic [DATA_W-1:0] ret_mem_addr;
    logic [DATA_W-1:0] ret_mem_data;
    logic              ret_halt;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_inum;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;
    logic [2:0]        out_kind;
    logic [REG_AW-1:0] out_reg;
    logic [DATA_W-1:0] out_value;
    logic [DATA_W-1:0] out_addr;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CNT_W-1:0]  out_cycle;
`endif
    logic              stall_req;
    logic              overflow;
    logic [CNT_W-1:0]  inst_count;
    logic [CNT_W-1:0]  cycle_count;
    logic              done;

    retire_trace_buffer #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ret_valid      (ret_valid),
        .ret_pc         (ret_pc),
        .ret_inst       (ret_inst),
        .ret_reg_write  (ret_reg_write),
        .ret_write_reg  (ret_write_reg),
        .ret_write_data (ret_write_data),
        .ret_mem_read   (ret_mem_read),
        .ret_mem_write  (ret_mem_write),
        .ret_mem_addr   (ret_mem_addr),
        .ret_mem_data   (ret_mem_data),
        .ret_halt       (ret_halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inum       (out_inum),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_kind       (out_kind),
        .out_reg        (out_reg),
        .out_value      (out_value),
        .out_addr       (out_addr),
`ifdef TRACE_CYCLE_STAMP_EN
        .out_cycle      (out_cycle),
`endif
        .stall_req      (stall_req),
        .overflow       (overflow),
        .inst_count     (inst_count),
        .cycle_count    (cycle_count),
        .done           (done)
    );

    typedef struct {
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic [2:0]        kind;
        logic [REG_AW-1:0] rg;
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] addr;
        logic [CNT_W-1:0]  cyc;
    } rec_t;

    rec_t expQ[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state as of the most recent clock edge
    int               mCount     = 0;
    int               mPhase     = 0;   // 0 run, 1 drain, 2 done
    logic [CNT_W-1:0] mInst      = '0;
    logic [CNT_W-1:0] mCycle     = '0;
    bit               mOverflow  = 1'b0;
    bit               mDone      = 1'b0;
    bit               mJustReset = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs that were present at that edge
    task automatic modelEdge();
        rec_t r;
        bit   popN;
        bit   wasFull;
        bit   wasDone;
        mJustReset = 1'b0;
        if (rst) begin
            expQ.delete();
            mCount = 0; mPhase = 0; mInst = '0; mCycle = '0;
            mOverflow = 1'b0; mDone = 1'b0; mJustReset = 1'b1;
            return;
        end
        wasDone = (mPhase == 2);
        popN    = (mCount > 0) && out_ready;
        wasFull = (mCount == DEPTH);
        if (popN) mCount--;
        if (ret_valid && mPhase == 0) begin
            if (ret_halt)                            r.kind = 3'd4;
            else if (ret_reg_write && ret_mem_read)  r.kind = 3'd2;
            else if (ret_reg_write)                  r.kind = 3'd1;
            else if (ret_mem_write)                  r.kind = 3'd3;
            else                                     r.kind = 3'd0;
            r.inum  = mInst;
            r.pc    = ret_pc;
            r.inst  = ret_inst;
            r.rg    = (r.kind == 3'd1 || r.kind == 3'd2) ? ret_write_reg : '0;
            r.value = (r.kind == 3'd1 || r.kind == 3'd2) ? ret_write_data :
                      (r.kind == 3'd3) ? ret_mem_data : '0;
            r.addr  = (r.kind == 3'd2 || r.kind == 3'd3) ? ret_mem_addr : '0;
            r.cyc   = mCycle;
            if (!wasFull || popN) begin
                expQ.push_back(r);
                mCount++;
            end else begin
                mOverflow = 1'b1;
            end
            if (mInst != '1) mInst = mInst + 1;
            if (ret_halt) mPhase = 1;
        end else if (mPhase == 1 && mCount == 0) begin
            mPhase = 2;
            mDone  = 1'b1;
        end
        if (!wasDone && mCycle != '1) mCycle = mCycle + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        modelEdge();
    endtask

    task automatic idle();
        ret_valid = 1'b0; ret_pc = '0; ret_inst = '0; ret_reg_write = 1'b0;
        ret_write_reg = '0; ret_write_data = '0; ret_mem_read = 1'b0;
        ret_mem_write = 1'b0; ret_mem_addr = '0; ret_mem_data = '0; ret_halt = 1'b0;
    endtask

    task automatic retire(input logic [15:0] pc, input logic [15:0] inst, input bit rw,
                          input logic [3:0] wr, input logic [15:0] wd, input bit mr,
                          input bit mw, input logic [15:0] ma, input logic [15:0] md,
                          input bit h);
        ret_valid = 1'b1; ret_pc = pc; ret_inst = inst; ret_reg_write = rw;
        ret_write_reg = wr; ret_write_data = wd; ret_mem_read = mr;
        ret_mem_write = mw; ret_mem_addr = ma; ret_mem_data = md; ret_halt = h;
    endtask

    task automatic retireRandom(input bit allowHalt);
        retire(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
               allowHalt && ($urandom_range(0, 15) == 0));
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: status against the model every cycle, head record against the scoreboard
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            chk("out_valid", 64'(out_valid), 64'(mCount > 0));
            chk("stall_req", 64'(stall_req), 64'(mCount == DEPTH));
            chk("overflow", 64'(overflow), 64'(mOverflow));
            chk("inst_count", 64'(inst_count), 64'(mInst));
            chk("cycle_count", 64'(cycle_count), 64'(mCycle));
            chk("done", 64'(done), 64'(mDone));
            if (mJustReset)
                chk("reset_fields", 64'(out_inum) | 64'(out_pc) | 64'(out_inst) | 64'(out_kind) |
                    64'(out_reg) | 64'(out_value) | 64'(out_addr), 64'd0);
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_record: got inum 0x%0h expected none at %0t", out_inum, $time);
                end else begin
                    r = expQ[0];
                    chk("inum", 64'(out_inum), 64'(r.inum));
                    chk("pc", 64'(out_pc), 64'(r.pc));
                    chk("inst", 64'(out_inst), 64'(r.inst));
                    chk("kind", 64'(out_kind), 64'(r.kind));
                    chk("reg", 64'(out_reg), 64'(r.rg));
                    chk("value", 64'(out_value), 64'(r.value));
                    chk("addr", 64'(out_addr), 64'(r.addr));
`ifdef TRACE_CYCLE_STAMP_EN
                    chk("cycle_stamp", 64'(out_cycle), 64'(r.cyc));
`endif
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Single register write
        out_ready = 1'b1;
        retire(16'h0002, 16'h8312, 1, 4'd3, 16'h1234, 0, 0, 16'h0, 16'h0, 0);
        tick();
        idle();
        repeat (2) tick();

        // Load, store, NOP
        doReset();
        retire(16'h0004, 16'h9540, 1, 4'd5, 16'hBEEF, 1, 0, 16'h0040, 16'h0, 0);
        tick();
        retire(16'h0006, 16'hA042, 0, 4'd0, 16'h0, 0, 1, 16'h0042, 16'h00AA, 0);
        tick();
        retire(16'h0008, 16'h0000, 0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        tick();
        idle();
        repeat (3) tick();

        // Nine retires against a stalled consumer, then push-with-pop on a full FIFO
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            retire(16'(2 * i), 16'h8000, 1, 4'(i), 16'(16'h100 + i), 0, 0, 16'h0, 16'h0, 0);
            tick();
        end
        idle();
        tick();
        out_ready = 1'b1;
        retire(16'h0040, 16'h8777, 1, 4'd7, 16'h7777, 0, 0, 16'h0, 16'h0, 0);
        tick();
        idle();
        repeat (DEPTH + 2) tick();

        // Random traffic without halts
        doReset();
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) retireRandom(1'b0);
            else idle();
            tick();
        end
        idle();
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();

        // Halt with three queued records, retires after halt ignored
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            retireRandom(1'b0);
            ret_halt = 1'b0;
            tick();
        end
        retire(16'h0030, 16'hF000, 0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            retireRandom(1'b0);
            tick();
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && !mDone; i++) tick();
        chk("halt_done_reached", 64'(mDone), 64'd1);
        repeat (5) begin
            retireRandom(1'b1);
            tick();
        end
        idle();

        // Reset asserted while draining
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            retireRandom(1'b0);
            tick();
        end
        retire(16'h0050, 16'hF000, 0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        tick();
        idle();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        retire(16'h0060, 16'h8111, 1, 4'd1, 16'h0111, 0, 0, 16'h0, 16'h0, 0);
        tick();
        idle();
        repeat (3) tick();

        // Random halt/drain runs with random back-pressure
        for (int run = 0; run < 4; run++) begin
            doReset();
            for (int i = 0; i < 80; i++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) != 0) retireRandom(1'b1);
                else idle();
                tick();
            end
            idle();
            out_ready = 1'b1;
            repeat (DEPTH + 3) tick();
        end

        @(negedge clk);
        chk("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
